// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, frame length and default
// start timeout, plus a small index helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } uart_state_e;

  // start + 8 data + parity + 2 stop, in baud periods
  localparam int UART_FRAME_BITS = 12;

  // cycles allowed between a latch pulse and the transmitter raising busy
  localparam int DEFAULT_START_TIMEOUT = 4;

  // next index after cur, wrapping modulo n
  function automatic int wrap_inc(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after index 'base', wrapping modulo N. 'any' is low when nothing is set.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_shift;
  logic [N-1:0]   w_rot;

  // rotate the request vector so that bit 0 corresponds to 'base'
  assign w_dbl   = {req, req};
  assign w_shift = w_dbl >> base;
  assign w_rot   = w_shift[N-1:0];

  // scan from the far end so the smallest offset from base wins
  always_comb begin
    int c;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        c = int'(base) + k;
        if (c >= N) c = c - N;
        idx = IDX_W'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// A grant stays locked to one requester until it sends a byte marked last,
// so multi-byte messages are never interleaved on the wire.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int IDX_W         = 2,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_latch,
  input  logic              tx_busy,
  output logic [IDX_W-1:0]  grant_id,
  output logic              locked,
  output logic              err
);

  // counter must be able to hold START_TIMEOUT-1; START_TIMEOUT is at least 1
  localparam int CNT_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  uart_state_e      r_state;
  uart_state_e      w_state_next;
  logic [7:0]       r_tx_data;
  logic             r_tx_latch;
  logic [IDX_W-1:0] r_grant_id;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic [IDX_W-1:0] w_sel;
  logic             w_sel_ok;
  logic [NREQ-1:0]  w_ready;
  logic             w_xfer;
  logic [7:0]       w_sel_data;
  logic             w_sel_last;
  logic             w_timeout;

  // search starts one past the last grant so every requester gets a turn
  assign w_base = (r_grant_id >= LAST_IDX) ? '0 : r_grant_id + IDX_W'(1);

  rr_pick #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req_valid),
    .base (w_base),
    .idx  (w_pick_idx),
    .any  (w_pick_any)
  );

  // a locked message holds the grant even if its owner drops valid
  assign w_sel    = r_locked ? r_grant_id : w_pick_idx;
  assign w_sel_ok = r_locked | w_pick_any;

  // ready is one-hot at most, and forced low while reset is held
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign w_ready[gi] = nrst & (r_state == ST_IDLE) & ~tx_busy & w_sel_ok &
                         (w_sel == IDX_W'(gi));
  end

  assign req_ready = w_ready;
  assign w_xfer    = |(req_valid & w_ready);

  // one-hot mux of the selected requester's byte and last flag
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_sel_data = req_data[8*i +: 8];
        w_sel_last = req_last[i];
      end
    end
  end

  assign w_timeout = (r_state == ST_WAIT_START) & ~tx_busy &
                     (r_cnt == CNT_W'(START_TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // next-state logic: latch, wait for busy to rise, then wait for it to fall
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (tx_busy)        w_state_next = ST_WAIT_DONE;
        else if (w_timeout) w_state_next = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // datapath: capture the byte on transfer, track lock, count start timeout
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_data  <= '0;
      r_tx_latch <= 1'b0;
      r_grant_id <= LAST_IDX;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_tx_latch <= w_xfer;
      if (w_xfer) begin
        r_tx_data  <= w_sel_data;
        r_grant_id <= w_sel;
        r_locked   <= ~w_sel_last;
        r_cnt      <= '0;
      end else if (r_state == ST_WAIT_START && !tx_busy) begin
        if (w_timeout) begin
          // transmitter never started: flag it and drop the message lock
          r_err    <= 1'b1;
          r_locked <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_latch = r_tx_latch;
  assign grant_id = r_grant_id;
  assign locked   = r_locked;
  assign err      = r_err;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `NREQ` on-chip requesters. Each requester offers bytes on a valid/ready handshake. The arbiter serialises them into the transmitter's `latch_data`/`busy` interface, one byte at a time. A grant is locked to one requester until it sends a byte marked `last`, so multi-byte messages are never interleaved. It sits between the bus-side logic and the transmitter in the UART top.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDX_W`, default 2: width of the requester index; must be ≥ clog2(`NREQ`).
- `START_TIMEOUT`, default 4: cycles to wait for `tx_busy` to rise after a latch pulse.

Ports:
- `clk` input 1: system clock (16 MHz).
- `nrst` input 1: asynchronous active-low reset.
- `req_valid` input NREQ: requester i has a byte.
- `req_data` input 8*NREQ: byte i is in bits [8i+7:8i].
- `req_last` input NREQ: byte i ends its message and releases the lock.
- `req_ready` output NREQ: combinational; a transfer happens when `req_valid[i] & req_ready[i]`.
- `tx_data` output 8: byte to the transmitter, registered.
- `tx_latch` output 1: one-cycle registered pulse into transmitter `latch_data`.
- `tx_busy` input 1: transmitter `busy`.
- `grant_id` output IDX_W: current or last granted requester.
- `locked` output 1: a message is in progress.
- `err` output 1: sticky; set on a start timeout and cleared only by reset.

## Operation
States:
- IDLE: waiting to accept a byte.
- WAIT_START: latch issued; waiting for the transmitter to go busy.
- WAIT_DONE: byte on the wire; waiting for the transmitter to go idle.

Selection:
- When `locked=0`, `sel` is the first i with `req_valid[i]=1`, searching from `grant_id+1` upward and wrapping modulo NREQ.
- When `locked=1`, `sel=grant_id` regardless of `req_valid`. Other requesters wait; there is no preemption.

Handshake:
- `req_ready[i] = (state==IDLE) & !tx_busy & (i==sel)`. At most one bit of `req_ready` is set.

On a transfer edge:
- `tx_data<=req_data[sel]`, `tx_latch<=1`, `grant_id<=sel`.
- `locked<=!req_last[sel]`.
- Go to WAIT_START and clear the timeout counter.

State transitions:
- WAIT_START: `tx_busy=1` → WAIT_DONE. If the counter reaches START_TIMEOUT first, set `err<=1`, set `locked<=0`, and go to IDLE.
- WAIT_DONE: `tx_busy=0` → IDLE.
- `tx_latch` is high for exactly one cycle per accepted byte and is never high outside the cycle after a transfer.

Boundaries:
- NREQ=1 degenerates to pass-through with lock tracking.
- Requests and the release arriving in the same cycle: the lock clears on that edge. The next selection starts from `grant_id+1`.
- If a locked requester drops valid, the arbiter stalls in IDLE indefinitely.
- `req_data` is sampled only on the transfer edge.

## Timing
- Reset values: state IDLE, `tx_data=0`, `tx_latch=0`, `grant_id=NREQ-1` (so requester 0 wins first), `locked=0`, `err=0`.
- `req_ready` is 0 during reset.
- Latency: transfer at edge N → `tx_latch` high in cycle N+1 → transmitter samples it at the end of N+1 → `tx_busy` high from N+2.
- Minimum spacing between latches is one full transmitter frame: 12 baud periods, about 1668 clk cycles at 115200 baud.
- Nothing is buffered inside the block; each requester holds its byte until ready.
- Reset mid-operation: all registers return immediately to their reset values. A byte already latched into the transmitter still completes on the wire.

## Structure
- Shared package `uart_pkg`:
  - state enum.
  - `UART_FRAME_BITS=12`.
  - default `START_TIMEOUT`.
- Sub-module `rr_pick`: combinational priority picker. Inputs are `req` and `base` index; outputs are `idx` and `any`. Reuse it for future RX-side scheduling.
- Total RTL is roughly 150-250 lines.

## Test plan
- Single byte: requester 0 sends 0x55 with `last=1` → one `tx_latch` pulse with `tx_data=0x55` → `locked=0`, `grant_id=0`.
- Fairness: all four requesters valid with `last=1` continuously → grant order 0,1,2,3,0. Each byte's latch is issued only after `tx_busy` falls.
- Lock: requester 1 sends 0x41,0x42,0x43 with `last` on 0x43 while requester 2 is valid → 2's `req_ready` stays 0 until after 0x43 is accepted; then 2 is granted.
- Busy gate: hold `tx_busy=1` externally with requester 3 valid → no `req_ready` and no `tx_latch`. Release → transfer within 1 cycle.
- Timeout: the transmitter model never raises busy after a latch → `err=1` after START_TIMEOUT cycles, state returns to IDLE, and the next request is accepted.
- Reset mid-message: assert `nrst` low during WAIT_DONE with `locked=1` → all outputs at reset values asynchronously. After release, requester 0 is granted first.
